control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Instruction register plus microstep sequencer for the 8-bit bus computer.
- Sits downstream of the program memory: captures the memory word from the shared bus into its IR.
- Emits the per-step control word, including mar_load, which drives the memory address register load.
- Sequences fetch (T0-T1) and execute (T2-T4) for a 4-bit opcode / 4-bit operand instruction format.

Parameters:
- NUM_STEPS, 5, microsteps per instruction (T0..T4); step counter wraps from NUM_STEPS-1 to 0.
- OPC_HLT, 4'hF, opcode that halts the sequencer.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bus  in  8  shared bus; IR loads from here.
- carry_flag  in  1  registered ALU carry.
- zero_flag  in  1  registered ALU zero.
- pc_out  out  1  PC drives bus.
- pc_inc  out  1  PC increments.
- pc_load  out  1  PC loads bus[3:0].
- mar_load  out  1  memory address register loads bus[3:0].
- ram_out  out  1  memory drives bus.
- ir_out  out  1  IR operand ({4'b0, ir[3:0]}) drives bus.
- a_load  out  1  A register loads from bus.
- a_out  out  1  A register drives bus.
- b_load  out  1  B register loads from bus.
- alu_out  out  1  ALU drives bus.
- alu_sub  out  1  ALU subtract select.
- flags_load  out  1  flag register captures carry/zero.
- out_load  out  1  output register loads from bus.
- halt  out  1  sticky halt indicator.
- step  out  3  current microstep (debug).
- opcode  out  4  ir[7:4] (debug).

Behaviour:
- State: ir[7:0], step[2:0], halted.
- Async reset: ir=0, step=0, halted=0.
- While rst=1, all control outputs are 0. After rst release, the T0 word is presented immediately.
- Control outputs are combinational from (step, ir[7:4], flags, halted); no extra latency.
- IR loads bus at the rising edge ending T1. During T1 the decoded opcode is still the previous instruction's; only the fetch word is used in T0/T1.
- Fetch:
  - T0: pc_out, mar_load.
  - T1: ram_out, pc_inc, internal ir_load.
- Execute (T2/T3/T4); unlisted steps are all-zero:
  - 0x0 NOP: none.
  - 0x1 LDA: T2 ir_out+mar_load; T3 ram_out+a_load.
  - 0x2 ADD: T2 ir_out+mar_load; T3 ram_out+b_load; T4 alu_out+a_load+flags_load.
  - 0x3 SUB: as ADD, with alu_sub also asserted in T4.
  - 0x5 LDI: T2 ir_out+a_load.
  - 0x6 JMP: T2 ir_out+pc_load.
  - 0x7 JC: T2 ir_out+pc_load only if carry_flag=1; else nothing.
  - 0x8 JZ: T2 ir_out+pc_load only if zero_flag=1; else nothing.
  - 0xE OUT: T2 a_out+out_load.
  - 0xF HLT: T2 sets halted at the clock edge ending T2.
  - 0x4, 0x9-0xD: treated as NOP.
- Flags are sampled combinationally during the step that uses them.
- Step counter: increments each clock; wraps NUM_STEPS-1 -> 0.
- Halted:
  - Step freezes and the IR does not load; all control outputs are 0 and halt=1.
  - Only rst clears halted.
- Reset mid-instruction: abandons the instruction; the next instruction after release is fetched from whatever PC provides.
- Bus-contention invariant: at most one of pc_out, ram_out, ir_out, a_out, alu_out is asserted in any cycle.

Optional Feature:
- Macro: CONTROL_SEQUENCER_EARLY_END_EN.
- Defined: after an instruction's last non-empty execute step, step returns to 0 on the next edge.
  - NOP/unused opcodes and untaken JC/JZ return from T2 to T0.
  - LDI/JMP/taken jumps/OUT: T2 -> T0.
  - LDA: T3 -> T0.
  - ADD/SUB run to T4.
  - HLT still freezes.
- Undefined: every instruction runs all NUM_STEPS steps.

Test Plan:
- Reset release with bus=8'h00, hold 2 clocks -> T0 word (pc_out=1, mar_load=1), then T1 word (ram_out=1, pc_inc=1); ir=8'h00 after the T1 edge; all outputs 0 while rst=1.
- bus=8'h1A at T1 (LDA 0xA) -> T2 ir_out=1, mar_load=1; T3 ram_out=1, a_load=1; T4 all zero (macro off) or step=0 at T4 (macro on).
- bus=8'h37 (SUB 7) -> T4 alu_out=1, a_load=1, flags_load=1, alu_sub=1; alu_sub=0 in every other step.
- bus=8'h75 (JC 5): carry_flag=0 -> T2 all zero; repeat with carry_flag=1 -> T2 ir_out=1, pc_load=1.
- bus=8'hF0 (HLT) -> after the T2 edge halt=1, step constant for 10 clocks, all controls 0; assert rst -> halt=0, step=0.
- rst pulsed asynchronously mid-T3 of ADD (between edges) -> step=0, ir=0 immediately; every cycle checked for one-hot bus drivers.

Source files
------------

// File: rtl/control_sequencer_if.sv
// control_sequencer_if
//   Groups the signals that pass between the control sequencer and the rest of
//   the 8-bit bus computer. The sequencer owns the master modport. The datapath,
//   or a testbench standing in for it, uses the slave modport.
//
//   Signals:
//     bus         8  shared bus value; the IR captures it during T1
//     carry_flag  1  registered ALU carry
//     zero_flag   1  registered ALU zero
//     pc_out .. out_load
//                 1  control word bits; see control_sequencer.sv
//     halt        1  sticky halt indicator
//     step        3  current microstep (debug)
//     opcode      4  ir[7:4] (debug)
//     operand     4  ir[3:0]; the datapath places {4'b0, operand} on the bus
//                    while ir_out is high
interface control_sequencer_if;
    logic [7:0] bus;
    logic       carry_flag;
    logic       zero_flag;
    logic       pc_out;
    logic       pc_inc;
    logic       pc_load;
    logic       mar_load;
    logic       ram_out;
    logic       ir_out;
    logic       a_load;
    logic       a_out;
    logic       b_load;
    logic       alu_out;
    logic       alu_sub;
    logic       flags_load;
    logic       out_load;
    logic       halt;
    logic [2:0] step;
    logic [3:0] opcode;
    logic [3:0] operand;

    modport master (
        input  bus, carry_flag, zero_flag,
        output pc_out, pc_inc, pc_load, mar_load, ram_out, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, flags_load,
               out_load, halt, step, opcode, operand
    );

    modport slave (
        output bus, carry_flag, zero_flag,
        input  pc_out, pc_inc, pc_load, mar_load, ram_out, ir_out,
               a_load, a_out, b_load, alu_out, alu_sub, flags_load,
               out_load, halt, step, opcode, operand
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer
//   Instruction register and microstep sequencer for the 8-bit bus computer.
//   Each instruction is fetched in T0-T1 and executed in T2-T4.
//   The instruction format is a 4-bit opcode in ir[7:4] and a 4-bit operand in
//   ir[3:0]. The control word is combinational from the step, the opcode, the
//   flags and the halt state, so it has no extra latency.
//
//   Ports:
//     clk  rising-edge system clock
//     rst  asynchronous, active-high reset. Clears the IR, the step and halt,
//          and forces every control output low while it is high.
//     ctl  control_sequencer_if.master: bus and flag inputs, control word,
//          debug outputs
//
//   Parameters:
//     NUM_STEPS  microsteps per instruction; the step counter wraps at
//                NUM_STEPS-1
//     OPC_HLT    opcode that freezes the sequencer until reset
//
//   Optional feature, selected by macro CONTROL_SEQUENCER_EARLY_END_EN:
//     When the macro is defined, step returns to T0 on the edge after an
//     instruction's last non-empty execute step. When it is undefined, every
//     instruction runs all NUM_STEPS steps.
module control_sequencer #(
    parameter int         NUM_STEPS = 5,
    parameter logic [3:0] OPC_HLT   = 4'hF
) (
    input logic                 clk,
    input logic                 rst,
    control_sequencer_if.master ctl
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    localparam logic [3:0] OPC_LDA = 4'h1;
    localparam logic [3:0] OPC_ADD = 4'h2;
    localparam logic [3:0] OPC_SUB = 4'h3;
    localparam logic [3:0] OPC_LDI = 4'h5;
    localparam logic [3:0] OPC_JMP = 4'h6;
    localparam logic [3:0] OPC_JC  = 4'h7;
    localparam logic [3:0] OPC_JZ  = 4'h8;
    localparam logic [3:0] OPC_OUT = 4'hE;

    step_t      step_q, step_d;
    logic [7:0] ir_q, ir_d;
    logic       halted_q, halted_d;
    logic       ir_load;
    logic [3:0] opc;
    logic [2:0] last_step;

    assign opc = ir_q[7:4];

`ifdef CONTROL_SEQUENCER_EARLY_END_EN
    // The instruction ends on its last step that drives anything. LDA finishes
    // in T3 and ADD/SUB use T4. Every other opcode, including an untaken jump,
    // is done after T2.
    always_comb begin
        last_step = T2;
        case (opc)
            OPC_LDA:          last_step = T3;
            OPC_ADD, OPC_SUB: last_step = T4;
            default:          last_step = T2;
        endcase
    end
`else
    // Without early end, every instruction walks through all the steps.
    assign last_step = LAST_STEP;
`endif

    // State register. Reset is asynchronous, so a pulse between edges abandons
    // the current instruction at once. The next fetch then starts from T0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q   <= T0;
            ir_q     <= 8'h00;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    // Next-state logic. The IR captures the bus on the edge that ends T1.
    // HLT sets halted on the edge that ends T2 and leaves the step parked at
    // T2. Once halted, nothing moves until reset.
    always_comb begin
        step_d   = step_q;
        ir_d     = ir_q;
        halted_d = halted_q;
        if (!halted_q) begin
            if (ir_load) begin
                ir_d = ctl.bus;
            end
            if (step_q == T2 && opc == OPC_HLT) begin
                halted_d = 1'b1;
            end else if (3'(step_q) == last_step) begin
                step_d = T0;
            end else begin
                step_d = step_t'(3'(step_q) + 3'd1);
            end
        end
    end

    // Control word decode. T0 and T1 are the fetch and ignore the opcode,
    // which still holds the previous instruction during T1. Reset and halt
    // both force the whole word low. At most one bus driver is raised in any
    // step, so the shared bus never has two drivers.
    always_comb begin
        ctl.pc_out     = 1'b0;
        ctl.pc_inc     = 1'b0;
        ctl.pc_load    = 1'b0;
        ctl.mar_load   = 1'b0;
        ctl.ram_out    = 1'b0;
        ctl.ir_out     = 1'b0;
        ctl.a_load     = 1'b0;
        ctl.a_out      = 1'b0;
        ctl.b_load     = 1'b0;
        ctl.alu_out    = 1'b0;
        ctl.alu_sub    = 1'b0;
        ctl.flags_load = 1'b0;
        ctl.out_load   = 1'b0;
        ir_load        = 1'b0;
        if (!rst && !halted_q) begin
            case (step_q)
                T0: begin
                    ctl.pc_out   = 1'b1;
                    ctl.mar_load = 1'b1;
                end
                T1: begin
                    ctl.ram_out = 1'b1;
                    ctl.pc_inc  = 1'b1;
                    ir_load     = 1'b1;
                end
                T2: begin
                    case (opc)
                        OPC_LDA, OPC_ADD, OPC_SUB: begin
                            ctl.ir_out   = 1'b1;
                            ctl.mar_load = 1'b1;
                        end
                        OPC_LDI: begin
                            ctl.ir_out = 1'b1;
                            ctl.a_load = 1'b1;
                        end
                        OPC_JMP: begin
                            ctl.ir_out  = 1'b1;
                            ctl.pc_load = 1'b1;
                        end
                        OPC_JC: begin
                            ctl.ir_out  = ctl.carry_flag;
                            ctl.pc_load = ctl.carry_flag;
                        end
                        OPC_JZ: begin
                            ctl.ir_out  = ctl.zero_flag;
                            ctl.pc_load = ctl.zero_flag;
                        end
                        OPC_OUT: begin
                            ctl.a_out    = 1'b1;
                            ctl.out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    case (opc)
                        OPC_LDA: begin
                            ctl.ram_out = 1'b1;
                            ctl.a_load  = 1'b1;
                        end
                        OPC_ADD, OPC_SUB: begin
                            ctl.ram_out = 1'b1;
                            ctl.b_load  = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    if (opc == OPC_ADD || opc == OPC_SUB) begin
                        ctl.alu_out    = 1'b1;
                        ctl.a_load     = 1'b1;
                        ctl.flags_load = 1'b1;
                        ctl.alu_sub    = (opc == OPC_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign ctl.halt    = halted_q;
    assign ctl.step    = 3'(step_q);
    assign ctl.opcode  = opc;
    assign ctl.operand = ir_q[3:0];

endmodule
